// File: rtl/sdram_port_arbiter_pkg.sv
// Shared definitions for the SDRAM port arbiter: controller command encoding,
// FSM state codes and the ownership helper used by the output mux.
package sdram_port_arbiter_pkg;

    typedef logic [1:0] sdram_cmd_t;

    localparam sdram_cmd_t CMD_IDLE  = 2'd0;
    localparam sdram_cmd_t CMD_READ  = 2'd1;
    localparam sdram_cmd_t CMD_WRITE = 2'd2;

    localparam int WAIT_CNT_W = 10;

    typedef enum logic [1:0] {
        S_C1_OWN     = 2'd0,
        S_WAIT_YIELD = 2'd1,
        S_C0_OWN     = 2'd2,
        S_HANDBACK   = 2'd3
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_C0   = 2'd1,
        OWN_C1   = 2'd2
    } owner_t;

    // C1 keeps the port while it is being asked to yield so it can finish its burst.
    function automatic owner_t owner_of(arb_state_t s);
        unique case (s)
            S_C1_OWN, S_WAIT_YIELD: return OWN_C1;
            S_C0_OWN:               return OWN_C0;
            default:                return OWN_NONE;
        endcase
    endfunction

endpackage

// File: rtl/sdram_port_arbiter_if.sv
// Client and controller bus of the SDRAM port arbiter; names are seen from the arbiter,
// so master is the arbiter side and slave is the clients/controller side.
interface sdram_port_arbiter_if
    import sdram_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = 22,
    parameter int DATA_W = 32
);
    logic              i_C0_Req;
    logic              o_C0_Grant;
    sdram_cmd_t        i_C0_Command;
    logic [ADDR_W-1:0] i_C0_Address;
    logic [DATA_W-1:0] i_C0_Data_Write;
    logic              o_C0_Data_Read_Valid;
    logic              o_C0_Data_Write_Done;

    logic              o_C1_SDRAM_Requested;
    logic              i_C1_SDRAM_Yield;
    sdram_cmd_t        i_C1_Command;
    logic [ADDR_W-1:0] i_C1_Address;
    logic [DATA_W-1:0] i_C1_Data_Write;
    logic              o_C1_Data_Read_Valid;
    logic              o_C1_Data_Write_Done;

    logic [DATA_W-1:0] o_Data_Read;
    sdram_cmd_t        o_Command;
    logic [ADDR_W-1:0] o_Data_Address;
    logic [DATA_W-1:0] o_Data_Write;
    logic              i_Data_Read_Valid;
    logic              i_Data_Write_Done;
    logic [DATA_W-1:0] i_Data_Read;

    logic              o_Yield_Timeout;

    modport master (
        input  i_C0_Req, i_C0_Command, i_C0_Address, i_C0_Data_Write,
        output o_C0_Grant, o_C0_Data_Read_Valid, o_C0_Data_Write_Done,
        input  i_C1_SDRAM_Yield, i_C1_Command, i_C1_Address, i_C1_Data_Write,
        output o_C1_SDRAM_Requested, o_C1_Data_Read_Valid, o_C1_Data_Write_Done,
        input  i_Data_Read_Valid, i_Data_Write_Done, i_Data_Read,
        output o_Data_Read, o_Command, o_Data_Address, o_Data_Write, o_Yield_Timeout
    );

    modport slave (
        output i_C0_Req, i_C0_Command, i_C0_Address, i_C0_Data_Write,
        input  o_C0_Grant, o_C0_Data_Read_Valid, o_C0_Data_Write_Done,
        output i_C1_SDRAM_Yield, i_C1_Command, i_C1_Address, i_C1_Data_Write,
        input  o_C1_SDRAM_Requested, o_C1_Data_Read_Valid, o_C1_Data_Write_Done,
        output i_Data_Read_Valid, i_Data_Write_Done, i_Data_Read,
        input  o_Data_Read, o_Command, o_Data_Address, o_Data_Write, o_Yield_Timeout
    );

endinterface

// File: rtl/sdram_port_arbiter.sv
// Shares the SDRAM controller port between the LCD reader (C0, priority) and the
// compute client (C1, default owner) using the request/yield handshake.
module sdram_port_arbiter
    import sdram_port_arbiter_pkg::*;
#(
    parameter int WAIT_MAX = 1023,
    parameter int ADDR_W   = 22,
    parameter int DATA_W   = 32
) (
    input  logic                 i_Clk,
    input  logic                 i_Reset,
    sdram_port_arbiter_if.master bus
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_MAX_C = WAIT_CNT_W'(WAIT_MAX);

    arb_state_t             state_q, state_d;
    logic [WAIT_CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic                   timeout_q, timeout_d;
    owner_t                 owner;
    sdram_cmd_t             mux_cmd;
    logic [ADDR_W-1:0]      mux_addr;
    logic [DATA_W-1:0]      mux_wdata;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would create order-dependent simulation races.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state_q    <= S_C1_OWN;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;

        unique case (state_q)
            S_C1_OWN:     if (bus.i_C0_Req) state_d = S_WAIT_YIELD;
            // A dropped request wins over a simultaneous yield: no grant is issued.
            S_WAIT_YIELD: if (!bus.i_C0_Req)             state_d = S_C1_OWN;
                          else if (bus.i_C1_SDRAM_Yield) state_d = S_C0_OWN;
            S_C0_OWN:     if (!bus.i_C0_Req && bus.i_C0_Command == CMD_IDLE) state_d = S_HANDBACK;
            S_HANDBACK:   state_d = S_C1_OWN;
            default:      state_d = S_C1_OWN;
        endcase

        if (state_q != S_WAIT_YIELD && state_d == S_WAIT_YIELD)
            wait_cnt_d = '0;
        else if (state_q == S_WAIT_YIELD && wait_cnt_q != WAIT_MAX_C)
            wait_cnt_d = wait_cnt_q + WAIT_CNT_W'(1);

        // Timeout only flags a slow yield; C1 is never forcibly preempted.
        if (state_q == S_WAIT_YIELD && wait_cnt_d == WAIT_MAX_C)
            timeout_d = 1'b1;
    end

    always_comb begin
        owner     = owner_of(state_q);
        mux_cmd   = CMD_IDLE;
        mux_addr  = bus.i_C1_Address;
        mux_wdata = bus.i_C1_Data_Write;
        unique case (owner)
            OWN_C1: mux_cmd = bus.i_C1_Command;
            OWN_C0: begin
                mux_cmd   = bus.i_C0_Command;
                mux_addr  = bus.i_C0_Address;
                mux_wdata = bus.i_C0_Data_Write;
            end
            default: mux_cmd = CMD_IDLE;
        endcase
    end

    assign bus.o_Command            = mux_cmd;
    assign bus.o_Data_Address       = mux_addr;
    assign bus.o_Data_Write         = mux_wdata;
    assign bus.o_Data_Read          = bus.i_Data_Read;

    assign bus.o_C0_Grant           = (state_q == S_C0_OWN);
    assign bus.o_C1_SDRAM_Requested = (state_q == S_WAIT_YIELD) || (state_q == S_C0_OWN);
    assign bus.o_Yield_Timeout      = timeout_q;

    assign bus.o_C0_Data_Read_Valid = bus.i_Data_Read_Valid && (owner == OWN_C0);
    assign bus.o_C0_Data_Write_Done = bus.i_Data_Write_Done && (owner == OWN_C0);
    assign bus.o_C1_Data_Read_Valid = bus.i_Data_Read_Valid && (owner == OWN_C1);
    assign bus.o_C1_Data_Write_Done = bus.i_Data_Write_Done && (owner == OWN_C1);

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: ownership handover, strobe routing,
// yield timeout and asynchronous reset, all against hand-computed values.
module tb_sdram_port_arbiter;
    import sdram_port_arbiter_pkg::*;

    logic i_Clk = 1'b0;
    logic i_Reset = 1'b1;
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 i_Clk = ~i_Clk;

    sdram_port_arbiter_if #(.ADDR_W(22), .DATA_W(32)) bus ();

    sdram_port_arbiter #(.WAIT_MAX(8), .ADDR_W(22), .DATA_W(32)) dut (
        .i_Clk   (i_Clk),
        .i_Reset (i_Reset),
        .bus     (bus.master)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are read 2 time units after the edge.
    task automatic step();
        @(posedge i_Clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish within 200000 time units");
        $fatal(1);
    end

    initial begin
        int c1_valids;
        int c0_valids;

        bus.i_C0_Req          = 1'b0;
        bus.i_C0_Command      = CMD_IDLE;
        bus.i_C0_Address      = '0;
        bus.i_C0_Data_Write   = '0;
        bus.i_C1_SDRAM_Yield  = 1'b0;
        bus.i_C1_Command      = CMD_IDLE;
        bus.i_C1_Address      = '0;
        bus.i_C1_Data_Write   = '0;
        bus.i_Data_Read_Valid = 1'b0;
        bus.i_Data_Write_Done = 1'b0;
        bus.i_Data_Read       = '0;
        repeat (2) @(posedge i_Clk);
        #2;
        check("rst_grant",   bus.o_C0_Grant,           1'b0);
        check("rst_request", bus.o_C1_SDRAM_Requested, 1'b0);
        check("rst_timeout", bus.o_Yield_Timeout,      1'b0);
        i_Reset = 1'b0;

        // C1 read passes through; ungranted C0 command is ignored; 4 valids go to C1 only.
        bus.i_C1_Command = CMD_READ;
        bus.i_C1_Address = 22'h000010;
        bus.i_C0_Command = CMD_WRITE;
        bus.i_C0_Address = 22'h3FFFFF;
        #1;
        check("t1_cmd",  bus.o_Command,      CMD_READ);
        check("t1_addr", bus.o_Data_Address, 22'h000010);
        c1_valids = 0;
        c0_valids = 0;
        for (int i = 0; i < 4; i++) begin
            bus.i_Data_Read_Valid = 1'b1;
            bus.i_Data_Read       = 32'hCAFE0000 + 32'(i);
            #1;
            if (bus.o_C1_Data_Read_Valid) c1_valids++;
            if (bus.o_C0_Data_Read_Valid) c0_valids++;
            check("t1_rdata", bus.o_Data_Read, 32'hCAFE0000 + 32'(i));
            step();
        end
        bus.i_Data_Read_Valid = 1'b0;
        check("t1_c1_valids", c1_valids, 4);
        check("t1_c0_valids", c0_valids, 0);
        bus.i_C1_Command = CMD_IDLE;
        bus.i_C0_Command = CMD_IDLE;

        // Yield already high on the request cycle still costs one cycle in S_WAIT_YIELD.
        bus.i_C0_Req         = 1'b1;
        bus.i_C1_SDRAM_Yield = 1'b1;
        step();
        check("t2_wait_grant",   bus.o_C0_Grant,           1'b0);
        check("t2_wait_request", bus.o_C1_SDRAM_Requested, 1'b1);
        step();
        check("t2_grant",        bus.o_C0_Grant,           1'b1);
        check("t2_request",      bus.o_C1_SDRAM_Requested, 1'b1);
        bus.i_C0_Command = CMD_READ;
        bus.i_C0_Address = 22'h020000;
        bus.i_Data_Read_Valid = 1'b1;
        #1;
        check("t2_cmd",      bus.o_Command,            CMD_READ);
        check("t2_addr",     bus.o_Data_Address,       22'h020000);
        check("t2_c0_valid", bus.o_C0_Data_Read_Valid, 1'b1);
        check("t2_c1_valid", bus.o_C1_Data_Read_Valid, 1'b0);
        bus.i_Data_Read_Valid = 1'b0;

        // C0 drops request mid-read: grant held until idle, one handback cycle, then C1.
        bus.i_C0_Req         = 1'b0;
        bus.i_C1_SDRAM_Yield = 1'b0;
        bus.i_C1_Command     = CMD_WRITE;
        step();
        check("t4_hold1_grant", bus.o_C0_Grant, 1'b1);
        check("t4_hold1_cmd",   bus.o_Command,  CMD_READ);
        step();
        check("t4_hold2_grant", bus.o_C0_Grant, 1'b1);
        bus.i_C0_Command = CMD_IDLE;
        step();
        check("t4_handback_grant",   bus.o_C0_Grant,           1'b0);
        check("t4_handback_cmd",     bus.o_Command,            CMD_IDLE);
        check("t4_handback_request", bus.o_C1_SDRAM_Requested, 1'b0);
        step();
        check("t4_c1_cmd", bus.o_Command, CMD_WRITE);
        bus.i_C1_Command = CMD_IDLE;

        // Request withdrawn during S_WAIT_YIELD wins over a simultaneous yield.
        bus.i_C0_Req = 1'b1;
        step();
        check("drop_wait_request", bus.o_C1_SDRAM_Requested, 1'b1);
        bus.i_C0_Req         = 1'b0;
        bus.i_C1_SDRAM_Yield = 1'b1;
        step();
        check("drop_grant",   bus.o_C0_Grant,           1'b0);
        check("drop_request", bus.o_C1_SDRAM_Requested, 1'b0);
        bus.i_C1_SDRAM_Yield = 1'b0;
        step();
        check("drop_grant_after", bus.o_C0_Grant, 1'b0);

        // C0 requests during a C1 write burst; C1 yields after its last write_done.
        bus.i_C1_Command    = CMD_WRITE;
        bus.i_C1_Address    = 22'h000100;
        bus.i_C1_Data_Write = 32'h11112222;
        bus.i_C0_Command    = CMD_READ;
        bus.i_C0_Address    = 22'h000200;
        bus.i_C0_Data_Write = 32'h99990000;
        bus.i_C0_Req        = 1'b1;
        step();
        check("t3_request", bus.o_C1_SDRAM_Requested, 1'b1);
        check("t3_grant",   bus.o_C0_Grant,           1'b0);
        check("t3_addr",    bus.o_Data_Address,       22'h000100);
        check("t3_wdata",   bus.o_Data_Write,         32'h11112222);
        for (int i = 0; i < 4; i++) begin
            bus.i_Data_Write_Done = 1'b1;
            #1;
            check("t3_burst_cmd",  bus.o_Command,            CMD_WRITE);
            check("t3_burst_c1",   bus.o_C1_Data_Write_Done, 1'b1);
            check("t3_burst_c0",   bus.o_C0_Data_Write_Done, 1'b0);
            check("t3_burst_gnt",  bus.o_C0_Grant,           1'b0);
            step();
        end
        bus.i_Data_Write_Done = 1'b0;
        bus.i_C1_Command      = CMD_IDLE;
        bus.i_C1_SDRAM_Yield  = 1'b1;
        #1;
        check("t3_yield_cmd", bus.o_Command, CMD_IDLE);
        step();
        check("t3_grant_after",  bus.o_C0_Grant,      1'b1);
        check("t3_c0_cmd",       bus.o_Command,       CMD_READ);
        check("t3_c0_addr",      bus.o_Data_Address,  22'h000200);
        check("t3_c0_wdata",     bus.o_Data_Write,    32'h99990000);
        check("t3_no_timeout",   bus.o_Yield_Timeout, 1'b0);
        bus.i_C0_Req         = 1'b0;
        bus.i_C0_Command     = CMD_IDLE;
        bus.i_C1_SDRAM_Yield = 1'b0;
        step();
        step();

        // C1 never yields: timeout sets after exactly 8 cycles in S_WAIT_YIELD, sticky.
        bus.i_C0_Req = 1'b1;
        step();
        for (int k = 1; k <= 10; k++) begin
            step();
            check("t5_timeout", bus.o_Yield_Timeout, (k >= 8) ? 1'b1 : 1'b0);
            check("t5_grant",   bus.o_C0_Grant,      1'b0);
        end
        bus.i_C0_Req = 1'b0;
        step();
        check("t5_sticky", bus.o_Yield_Timeout, 1'b1);

        // Asynchronous reset during a C0 burst.
        bus.i_C1_Command     = CMD_WRITE;
        bus.i_C1_Address     = 22'h000300;
        bus.i_C0_Req         = 1'b1;
        bus.i_C1_SDRAM_Yield = 1'b1;
        step();
        step();
        bus.i_C0_Command      = CMD_READ;
        bus.i_Data_Read_Valid = 1'b1;
        #1;
        check("t6_pre_grant",    bus.o_C0_Grant,           1'b1);
        check("t6_pre_c0_valid", bus.o_C0_Data_Read_Valid, 1'b1);
        i_Reset = 1'b1;
        #1;
        check("t6_rst_grant",    bus.o_C0_Grant,           1'b0);
        check("t6_rst_request",  bus.o_C1_SDRAM_Requested, 1'b0);
        check("t6_rst_timeout",  bus.o_Yield_Timeout,      1'b0);
        check("t6_rst_cmd",      bus.o_Command,            CMD_WRITE);
        check("t6_rst_c1_valid", bus.o_C1_Data_Read_Valid, 1'b1);
        check("t6_rst_c0_valid", bus.o_C0_Data_Read_Valid, 1'b0);
        bus.i_Data_Read_Valid = 1'b0;
        bus.i_C0_Req          = 1'b0;
        bus.i_C0_Command      = CMD_IDLE;
        bus.i_C1_SDRAM_Yield  = 1'b0;
        i_Reset = 1'b0;
        step();
        check("t6_post_grant",   bus.o_C0_Grant,           1'b0);
        check("t6_post_request", bus.o_C1_SDRAM_Requested, 1'b0);
        check("t6_post_cmd",     bus.o_Command,            CMD_WRITE);
        check("t6_post_addr",    bus.o_Data_Address,       22'h000300);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
